// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with baud divider and input FIFO.
// Runtime parity and one/two stop bits, back-to-back frames.
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [DATA_WIDTH-1:0]         P_DATA,
    input  logic                          Data_Valid,
    output logic                          ready,
    input  logic [DIV_WIDTH-1:0]          Baud_Div,
    input  logic                          parity_enable,
    input  logic                          parity_type,
    input  logic                          two_stop,
    output logic                          TX_OUT,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t state_n;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  push;
    logic                  pop;
    logic                  have_word;
    logic [DATA_WIDTH-1:0] head;

    logic [DATA_WIDTH-1:0] shift_q;
    logic [DIV_WIDTH-1:0]  baud_cnt;
    logic [DIV_WIDTH-1:0]  div_q;
    logic [DIV_WIDTH-1:0]  div_eff;
    logic [BW-1:0]         bit_idx;
    logic                  stop_idx;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  two_q;
    logic                  tx_q;
    logic                  ovf_q;

    logic                  bit_done;
    logic                  last_bit;
    logic                  last_stop;

    assign ready      = (count < CW'(FIFO_DEPTH));
    assign push       = Data_Valid && ready;
    assign have_word  = (count != '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    assign overflow   = ovf_q;
    assign TX_OUT     = tx_q;
    assign busy       = (state != IDLE);

    assign div_eff   = (Baud_Div == '0) ? DIV_WIDTH'(1) : Baud_Div;
    assign bit_done  = (baud_cnt == '0);
    assign last_bit  = (bit_idx == BW'(DATA_WIDTH - 1));
    assign last_stop = !two_q || stop_idx;

    // FIFO storage: payload only, no reset needed
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= P_DATA;
        end
    end

    // FIFO pointers, occupancy and registered overflow pulse
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            ovf_q <= Data_Valid && !ready;
        end
    end

    // Frame state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and FIFO pop; a pop always starts a new frame
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (have_word) begin
                    state_n = START;
                    pop     = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_done && last_bit) begin
                    state_n = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_n = STOP;
                end
            end
            STOP: begin
                if (bit_done && last_stop) begin
                    if (have_word) begin
                        state_n = START;
                        pop     = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Bit timer, shifter, latched frame options and registered line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_q   <= '0;
            baud_cnt  <= '0;
            div_q     <= DIV_WIDTH'(1);
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            two_q     <= 1'b0;
            tx_q      <= 1'b1;
        end else if (pop) begin
            shift_q   <= head;
            div_q     <= div_eff;
            baud_cnt  <= div_eff - DIV_WIDTH'(1);
            par_en_q  <= parity_enable;
            two_q     <= two_stop;
            par_bit_q <= (^head) ^ parity_type;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            tx_q      <= 1'b0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            tx_q     <= 1'b1;
        end else if (!bit_done) begin
            baud_cnt <= baud_cnt - DIV_WIDTH'(1);
        end else begin
            baud_cnt <= div_q - DIV_WIDTH'(1);
            unique case (state)
                START: begin
                    tx_q <= shift_q[0];
                end
                DATA: begin
                    if (last_bit) begin
                        tx_q     <= par_en_q ? par_bit_q : 1'b1;
                        stop_idx <= 1'b0;
                    end else begin
                        shift_q <= shift_q >> 1;
                        tx_q    <= shift_q[1];
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                PARITY: begin
                    tx_q <= 1'b1;
                end
                STOP: begin
                    stop_idx <= 1'b1;
                    tx_q     <= 1'b1;
                end
                default: begin
                    tx_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and random checks of uart_tx_fifo
// against a queue-based model of the serial line.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int DIVW  = 16;

    logic            CLK = 1'b0;
    logic            RST;
    logic [DW-1:0]   P_DATA;
    logic            Data_Valid;
    logic            ready;
    logic [DIVW-1:0] Baud_Div;
    logic            parity_enable;
    logic            parity_type;
    logic            two_stop;
    logic            TX_OUT;
    logic            busy;
    logic [3:0]      fifo_count;
    logic            overflow;

    int checks = 0;
    int errors = 0;
    int busy_run = 0;
    int ovf_pulses = 0;

    logic [DW-1:0] m_fifo [$];
    logic          m_line [$];
    logic          m_ovf = 1'b0;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .DIV_WIDTH  (DIVW)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .P_DATA        (P_DATA),
        .Data_Valid    (Data_Valid),
        .ready         (ready),
        .Baud_Div      (Baud_Div),
        .parity_enable (parity_enable),
        .parity_type   (parity_type),
        .two_stop      (two_stop),
        .TX_OUT        (TX_OUT),
        .busy          (busy),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, clock, compare.
    task automatic cycle(input logic dv, input logic [DW-1:0] d);
        int            sz;
        int            div;
        logic [DW-1:0] w;
        logic          bits [$];
        logic          etx;
        logic          ebusy;
        Data_Valid = dv;
        P_DATA     = d;
        sz = m_fifo.size();
        if (m_line.size() == 0 && sz != 0) begin
            w   = m_fifo.pop_front();
            div = (Baud_Div == 0) ? 1 : int'(Baud_Div);
            bits.push_back(1'b0);
            for (int i = 0; i < DW; i++) bits.push_back(w[i]);
            if (parity_enable) bits.push_back((^w) ^ parity_type);
            bits.push_back(1'b1);
            if (two_stop) bits.push_back(1'b1);
            foreach (bits[i]) begin
                for (int r = 0; r < div; r++) m_line.push_back(bits[i]);
            end
        end
        m_ovf = dv && (sz >= DEPTH);
        if (dv && sz < DEPTH) m_fifo.push_back(d);
        @(posedge CLK);
        #1;
        if (m_line.size() != 0) begin
            etx   = m_line.pop_front();
            ebusy = 1'b1;
        end else begin
            etx   = 1'b1;
            ebusy = 1'b0;
        end
        chk("tx", TX_OUT, etx);
        chk("busy", busy, ebusy);
        chk("count", fifo_count, m_fifo.size());
        chk("ovf", overflow, m_ovf);
        chk("ready", ready, m_fifo.size() < DEPTH);
        if (busy) busy_run++;
        if (overflow) ovf_pulses++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0);
    endtask

    initial begin
        RST = 1'b1;
        Data_Valid = 1'b0;
        P_DATA = '0;
        Baud_Div = 16'd4;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        two_stop = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tx", TX_OUT, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        RST = 1'b0;

        // single 0xA5, 8N1, 4 clocks per bit
        busy_run = 0;
        cycle(1'b1, 8'hA5);
        idle(45);
        chk("t1_len", busy_run, 40);

        // odd parity
        parity_enable = 1'b1;
        parity_type = 1'b1;
        busy_run = 0;
        cycle(1'b1, 8'hA5);
        idle(48);
        chk("t2_odd_len", busy_run, 44);

        // even parity, two stop bits
        parity_type = 1'b0;
        two_stop = 1'b1;
        busy_run = 0;
        cycle(1'b1, 8'hA5);
        idle(52);
        chk("t2_even_len", busy_run, 48);

        // three back-to-back frames
        parity_enable = 1'b0;
        two_stop = 1'b0;
        busy_run = 0;
        cycle(1'b1, 8'h01);
        chk("t3_cnt0", fifo_count, 1);
        cycle(1'b1, 8'h02);
        chk("t3_cnt1", fifo_count, 1);
        cycle(1'b1, 8'h03);
        chk("t3_cnt2", fifo_count, 2);
        idle(125);
        chk("t3_len", busy_run, 120);

        // overflow with Data_Valid held for 10 cycles
        Baud_Div = 16'd100;
        ovf_pulses = 0;
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'($urandom));
        chk("t4_full", fifo_count, 8);
        chk("t4_ready", ready, 0);
        idle(3);
        chk("t4_pulses", ovf_pulses, 1);
        idle(9 * 1000 + 10);

        // divider change mid-frame, then divider 0
        Baud_Div = 16'd4;
        busy_run = 0;
        cycle(1'b1, DW'($urandom));
        cycle(1'b1, DW'($urandom));
        idle(10);
        Baud_Div = 16'd8;
        idle(130);
        chk("t5_len", busy_run, 120);
        Baud_Div = 16'd0;
        busy_run = 0;
        cycle(1'b1, DW'($urandom));
        idle(15);
        chk("t5_div0_len", busy_run, 10);

        // reset mid DATA with three words queued
        Baud_Div = 16'd4;
        cycle(1'b1, 8'h00);
        for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom));
        idle(8);
        chk("t6_pre_cnt", fifo_count, 3);
        #2;
        RST = 1'b1;
        #1;
        chk("t6_rst_tx", TX_OUT, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_cnt", fifo_count, 0);
        m_fifo.delete();
        m_line.delete();
        m_ovf = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        busy_run = 0;
        idle(30);
        chk("t6_quiet", busy_run, 0);

        // random traffic and frame options
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                Baud_Div = DIVW'($urandom_range(0, 3));
                parity_enable = 1'($urandom);
                parity_type = 1'($urandom);
                two_stop = 1'($urandom);
            end
            cycle($urandom_range(0, 9) == 0, DW'($urandom));
        end
        idle(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated baud divider, a DEPTH-entry input FIFO and runtime frame options: parity and one or two stop bits. It succeeds the fixed-width, externally clocked TX path in the UART top. It runs on a single system clock, so no dedicated TX clock or clock mux is needed. It accepts parallel words from the host side and serialises them LSB-first onto TX_OUT, sending queued frames back-to-back.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..9)
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- DIV_WIDTH, 16, width of Baud_Div
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- P_DATA  in  DATA_WIDTH  word to transmit
- Data_Valid  in  1  write request; accepted when Data_Valid && ready
- ready  out  1  FIFO not full (registered count < FIFO_DEPTH)
- Baud_Div  in  DIV_WIDTH  CLK cycles per bit; 0 treated as 1
- parity_enable  in  1  insert parity bit after data
- parity_type  in  1  0 = even, 1 = odd
- two_stop  in  1  0 = one stop bit, 1 = two stop bits
- TX_OUT  out  1  serial line, registered, idles high
- busy  out  1  frame in progress
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries stored
- overflow  out  1  one-cycle pulse when a write is dropped

## Operation
- Reset values: TX_OUT=1, busy=0, ready=1, fifo_count=0, overflow=0, FSM=IDLE, FIFO pointers cleared.
- Reset during a frame aborts it. TX_OUT returns high asynchronously. Queued data is discarded.
- FIFO write: P_DATA is stored when Data_Valid && ready.
- FIFO full: ready=0. A write with Data_Valid=1 is dropped and overflow=1 for the next cycle. This holds even if a pop occurs on the same edge.
- Simultaneous write and pop: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE→START: taken on an edge where fifo_count≠0. On that edge:
  - the head word is popped into the shift register;
  - Baud_Div, parity_enable, parity_type and two_stop are latched;
  - the parity bit is computed from the popped word.
- Configuration inputs changed mid-frame take effect at the next frame only.
- START→DATA after 1 bit period.
- DATA: DATA_WIDTH bits, LSB first, one bit period each. Then PARITY if parity_enable is latched, else STOP.
- PARITY: 1 bit period. Bit value is XOR of data bits, XOR parity_type.
- STOP: 1 or 2 bit periods of TX_OUT=1. At the end:
  - if fifo_count≠0, go directly to START and pop (no idle gap);
  - otherwise go to IDLE.
- Bit period is a down-counter reloaded with max(Baud_Div,1)−1 at each bit boundary.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE.

## Timing
- Write on edge k → fifo_count updates after edge k.
- From IDLE: pop on edge k+1. TX_OUT=0 and busy=1 from edge k+1.
- A write into an empty FIFO is never popped on the same edge.
- Every bit lasts exactly max(Baud_Div,1) cycles.
- Frame length: max(Baud_Div,1) × (2 + DATA_WIDTH + parity_enable + two_stop) cycles.
- Back-to-back frames: the next start bit begins on the edge that ends the last stop bit. busy stays high with no gap.
- overflow is registered: high for exactly one cycle after the dropped write edge.

## Test plan
- Send one word 0xA5 with DATA_WIDTH=8, Baud_Div=4, no parity, one stop bit. Required: TX_OUT = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. busy high for 40 cycles, then TX_OUT=1 and busy=0.
- Send 0xA5 with parity_enable=1. Odd parity → parity bit 1. Even parity → parity bit 0. With two_stop=1, frame = 48 cycles at Baud_Div=4.
- Write 0x01, 0x02, 0x03 on consecutive cycles with Baud_Div=4. Required: three contiguous 40-cycle frames, busy high for 120 cycles, fifo_count sequence 1,1,2 then draining to 0.
- FIFO_DEPTH=8, Baud_Div=100, Data_Valid held for 10 consecutive cycles. Required: 9 words accepted (the first is popped on the 2nd edge). ready=0 after the 9th edge. The 10th word is dropped, overflow pulses once, and fifo_count=8.
- Change Baud_Div from 4 to 8 mid-frame. Required: current frame keeps 4-cycle bits, next frame uses 8-cycle bits. With Baud_Div=0, bits last 1 cycle.
- Assert RST during the DATA state with 3 words queued. Required: TX_OUT=1, busy=0 and fifo_count=0 immediately. After release, no frame is sent until a new write.
